// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Multi-cycle controller for a four-register, 8-bit
//             add / multiply / load-immediate datapath. Accepts instruction
//             bytes over a valid/ready handshake, drives the register-file
//             read decoders, the one-hot result-bus drivers and the
//             destination write strobe, and holds operands stable for the
//             whole multiplier settle time.
//
//  Parameters
//    MUL_CYCLES   EXEC cycles for a multiply (values below 1 act as 1)
//
//  Ports
//    ck           in   1  clock, rising edge
//    clear        in   1  asynchronous active-low reset
//    instr        in   8  [7:6] opcode, [5:4] dest, [3:2] src A, [1:0] src B
//    instr_valid  in   1  instr holds a valid byte
//    instr_ready  out  1  byte is accepted on the next rising edge
//    rd_en        out  1  enable for both read decoders
//    rd_a_sel     out  2  src A register index
//    rd_b_sel     out  2  src B register index
//    res_en       out  3  one-hot result driver: [0] add, [1] imm, [2] mul
//    imm          out  8  immediate value for the result bus
//    wr_sel       out  2  destination register index
//    wr_stb       out  1  one-cycle destination write strobe
//    busy         out  1  instruction in flight
//    illegal      out  1  one-cycle pulse on opcode 2'b10
//    retired      out  8  completed-write count, wraps
//
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       ck,
  input  logic       clear,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic       rd_en,
  output logic [1:0] rd_a_sel,
  output logic [1:0] rd_b_sel,
  output logic [2:0] res_en,
  output logic [7:0] imm,
  output logic [1:0] wr_sel,
  output logic       wr_stb,
  output logic       busy,
  output logic       illegal,
  output logic [7:0] retired
);

  // Multiply length clamped to at least one EXEC cycle.
  localparam int c_MUL_EFF = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MUL_EFF + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MUL = c_CNT_W'(c_MUL_EFF);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_LDI = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b11;

  localparam logic [2:0] c_RES_ADD = 3'b001;
  localparam logic [2:0] c_RES_IMM = 3'b010;
  localparam logic [2:0] c_RES_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [1:0]           r_dest;

  logic                 r_instr_ready;
  logic                 r_rd_en;
  logic [1:0]           r_rd_a_sel;
  logic [1:0]           r_rd_b_sel;
  logic [2:0]           r_res_en;
  logic [7:0]           r_imm;
  logic [1:0]           r_wr_sel;
  logic                 r_wr_stb;
  logic                 r_busy;
  logic                 r_illegal;
  logic [7:0]           r_retired;

  // Handshake uses the registered ready, so a byte is taken exactly on the
  // edge that also drops ready (no combinational path from valid to ready).
  logic                 w_hs;
  logic [1:0]           w_op;

  assign w_hs = instr_valid & r_instr_ready;
  assign w_op = instr[7:6];

  always_ff @(posedge ck or negedge clear) begin
    if (!clear) begin
      r_state       <= S_FETCH;
      r_cnt         <= '0;
      r_dest        <= 2'd0;
      r_instr_ready <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_a_sel    <= 2'd0;
      r_rd_b_sel    <= 2'd0;
      r_res_en      <= 3'b000;
      r_imm         <= 8'd0;
      r_wr_sel      <= 2'd0;
      r_wr_stb      <= 1'b0;
      r_busy        <= 1'b0;
      r_illegal     <= 1'b0;
      r_retired     <= 8'd0;
    end else begin
      // Single-cycle pulses default low every cycle.
      r_wr_stb  <= 1'b0;
      r_illegal <= 1'b0;

      case (r_state)
        S_FETCH: begin
          // Ready comes up one edge after reset release or an illegal byte.
          r_instr_ready <= 1'b1;
          if (w_hs) begin
            case (w_op)
              c_OP_ADD, c_OP_MUL: begin
                r_state       <= S_EXEC;
                r_instr_ready <= 1'b0;
                r_busy        <= 1'b1;
                r_rd_en       <= 1'b1;
                r_rd_a_sel    <= instr[3:2];
                r_rd_b_sel    <= instr[1:0];
                r_dest        <= instr[5:4];
                r_res_en      <= (w_op == c_OP_MUL) ? c_RES_MUL : c_RES_ADD;
                r_cnt         <= (w_op == c_OP_MUL) ? c_CNT_MUL : c_CNT_ONE;
              end
              c_OP_LDI: begin
                // Ready stays high: the next accepted byte is the immediate.
                r_state <= S_IMM;
                r_busy  <= 1'b1;
                r_dest  <= instr[5:4];
              end
              default: begin
                // Opcode 10: flag it, swallow the byte, stay in FETCH.
                r_instr_ready <= 1'b0;
                r_illegal     <= 1'b1;
              end
            endcase
          end
        end

        S_IMM: begin
          if (w_hs) begin
            r_state       <= S_EXEC;
            r_instr_ready <= 1'b0;
            r_imm         <= instr;
            r_rd_en       <= 1'b0;
            r_rd_a_sel    <= 2'd0;
            r_rd_b_sel    <= 2'd0;
            r_res_en      <= c_RES_IMM;
            r_cnt         <= c_CNT_ONE;
          end
        end

        S_EXEC: begin
          // Operands and result driver stay put while the counter runs down.
          if (r_cnt == c_CNT_ONE) begin
            r_state   <= S_WRITE;
            r_wr_stb  <= 1'b1;
            r_wr_sel  <= r_dest;
            r_retired <= r_retired + 8'd1;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_WRITE: begin
          // Read enables and result drivers release only after the strobe.
          r_state       <= S_FETCH;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_rd_en       <= 1'b0;
          r_res_en      <= 3'b000;
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign rd_en       = r_rd_en;
  assign rd_a_sel    = r_rd_a_sel;
  assign rd_b_sel    = r_rd_b_sel;
  assign res_en      = r_res_en;
  assign imm         = r_imm;
  assign wr_sel      = r_wr_sel;
  assign wr_stb      = r_wr_stb;
  assign busy        = r_busy;
  assign illegal     = r_illegal;
  assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Self-checking bench for alu_sequencer. A schedule-based model
//             predicts every output cycle; directed scenarios pin the model
//             with literal expectations, then randomized traffic follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int MUL_CYCLES = 4;
  localparam int c_MUL_EFF  = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;

  logic       ck = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] instr = 8'd0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       rd_en;
  logic [1:0] rd_a_sel;
  logic [1:0] rd_b_sel;
  logic [2:0] res_en;
  logic [7:0] imm;
  logic [1:0] wr_sel;
  logic       wr_stb;
  logic       busy;
  logic       illegal;
  logic [7:0] retired;

  alu_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .ck          (ck),
    .clear       (clear),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rd_en       (rd_en),
    .rd_a_sel    (rd_a_sel),
    .rd_b_sel    (rd_b_sel),
    .res_en      (res_en),
    .imm         (imm),
    .wr_sel      (wr_sel),
    .wr_stb      (wr_stb),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: every accepted instruction expands into a list of
  // expected output cycles; when the list is empty the sequencer is idle.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic       full;   // reset cycle: every output is defined
    logic       ready;
    logic       rd;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] res;
    logic [7:0] imm;
    logic [1:0] wsel;
    logic       stb;
    logic       busy;
    logic       ill;
  } rec_t;

  rec_t       cur;
  rec_t       q[$];
  logic       m_wait;
  logic [1:0] m_dest;
  logic [7:0] m_ret;

  function automatic rec_t mk_idle(input logic waiting);
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    r.busy  = waiting;
    return r;
  endfunction

  function automatic rec_t mk_op(input logic [2:0] res, input logic rdv,
                                 input logic [1:0] a, input logic [1:0] b,
                                 input logic [7:0] iv, input logic [1:0] dest,
                                 input logic stb);
    rec_t r;
    r = '0;
    r.rd   = rdv;
    r.a    = a;
    r.b    = b;
    r.res  = res;
    r.imm  = iv;
    r.wsel = dest;
    r.stb  = stb;
    r.busy = 1'b1;
    return r;
  endfunction

  function automatic rec_t mk_ill();
    rec_t r;
    r = '0;
    r.ill = 1'b1;
    return r;
  endfunction

  always @(posedge ck or negedge clear) begin
    if (!clear) begin
      q.delete();
      cur      = '0;
      cur.full = 1'b1;
      m_wait   = 1'b0;
      m_dest   = 2'd0;
      m_ret    = 8'd0;
    end else begin
      if (cur.ready && instr_valid) begin
        if (m_wait) begin
          m_wait = 1'b0;
          q.push_back(mk_op(3'b010, 1'b0, 2'd0, 2'd0, instr, m_dest, 1'b0));
          q.push_back(mk_op(3'b010, 1'b0, 2'd0, 2'd0, instr, m_dest, 1'b1));
        end else begin
          case (instr[7:6])
            2'b00: begin
              q.push_back(mk_op(3'b001, 1'b1, instr[3:2], instr[1:0], 8'd0, instr[5:4], 1'b0));
              q.push_back(mk_op(3'b001, 1'b1, instr[3:2], instr[1:0], 8'd0, instr[5:4], 1'b1));
            end
            2'b11: begin
              for (int k = 0; k < c_MUL_EFF; k++)
                q.push_back(mk_op(3'b100, 1'b1, instr[3:2], instr[1:0], 8'd0, instr[5:4], 1'b0));
              q.push_back(mk_op(3'b100, 1'b1, instr[3:2], instr[1:0], 8'd0, instr[5:4], 1'b1));
            end
            2'b01: begin
              m_wait = 1'b1;
              m_dest = instr[5:4];
            end
            default: q.push_back(mk_ill());
          endcase
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = mk_idle(m_wait);
      if (cur.stb) m_ret = m_ret + 8'd1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge ck) begin
    chk("instr_ready", instr_ready, cur.ready);
    chk("busy",        busy,        cur.busy);
    chk("illegal",     illegal,     cur.ill);
    chk("wr_stb",      wr_stb,      cur.stb);
    chk("rd_en",       rd_en,       cur.rd);
    chk("res_en",      res_en,      cur.res);
    chk("retired",     retired,     m_ret);
    if (cur.full || cur.rd) begin
      chk("rd_a_sel", rd_a_sel, cur.a);
      chk("rd_b_sel", rd_b_sel, cur.b);
    end
    if (cur.full || cur.res[1]) chk("imm", imm, cur.imm);
    if (cur.full || cur.stb)    chk("wr_sel", wr_sel, cur.wsel);
  end

  always @(negedge ck) if (wr_stb) stb_cnt++;

  // Offer byte b; returns at the falling edge just after it was accepted.
  // Before acceptance instr is scrambled whenever ready is low.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge ck);
    instr_valid = 1'b1;
    while (!instr_ready && t < 64) begin
      instr = 8'($urandom);
      @(negedge ck);
      t++;
    end
    if (t >= 64) chk("send_timeout", 0, 1);
    instr = b;
    @(negedge ck);
    instr_valid = 1'b0;
    instr = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int         s0;
  logic [7:0] r0;
  logic [7:0] rb;
  int         sent;
  logic       took;

  initial begin
    #2 clear = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_retired",     retired,     0);
    chk("rst_res_en",      res_en,      0);
    clear = 1'b1;
    @(negedge ck);
    chk("release_ready", instr_ready, 1);

    // ADD 0x1B: dest 1, A 2, B 3
    s0 = stb_cnt;
    send(8'h1B);
    chk("add_a",   rd_a_sel, 2);
    chk("add_b",   rd_b_sel, 3);
    chk("add_res", res_en,   1);
    chk("add_nostb_e0", wr_stb, 0);
    @(negedge ck);
    chk("add_stb",     wr_stb,  1);
    chk("add_wr_sel",  wr_sel,  1);
    chk("add_retired", retired, 1);
    @(negedge ck);
    chk("add_stb_off", wr_stb,      0);
    chk("add_ready",   instr_ready, 1);
    #1 chk("add_stb_count", stb_cnt - s0, 1);

    // MUL 0xF6: dest 3, A 1, B 2
    s0 = stb_cnt;
    send(8'hF6);
    for (int k = 0; k < 4; k++) begin
      chk("mul_res",    res_en, 4);
      chk("mul_rd_en",  rd_en,  1);
      chk("mul_nostb",  wr_stb, 0);
      chk("mul_a",      rd_a_sel, 1);
      @(negedge ck);
    end
    chk("mul_stb",    wr_stb, 1);
    chk("mul_wr_sel", wr_sel, 3);
    @(negedge ck);
    #1 chk("mul_stb_count", stb_cnt - s0, 1);

    // LDI 0x50 with a 3-cycle bubble, then immediate 0xA5
    s0 = stb_cnt;
    send(8'h50);
    chk("ldi_busy0", busy, 1);
    repeat (3) begin
      @(negedge ck);
      chk("ldi_gap_busy",  busy,        1);
      chk("ldi_gap_ready", instr_ready, 1);
    end
    send(8'hA5);
    chk("ldi_imm",   imm,    8'hA5);
    chk("ldi_res",   res_en, 2);
    chk("ldi_rd_en", rd_en,  0);
    @(negedge ck);
    chk("ldi_stb",    wr_stb, 1);
    chk("ldi_wr_sel", wr_sel, 1);
    chk("ldi_imm_w",  imm,    8'hA5);
    @(negedge ck);
    #1 chk("ldi_stb_count", stb_cnt - s0, 1);

    // Illegal byte then ADD, accepted at e2
    s0 = stb_cnt;
    r0 = retired;
    send(8'h80);
    chk("ill_pulse", illegal,     1);
    chk("ill_ready", instr_ready, 0);
    send(8'h1B);
    chk("ill_add_busy",  busy,    1);
    chk("ill_add_res",   res_en,  1);
    chk("ill_retired",   retired, r0);
    #1 chk("ill_stb_count", stb_cnt - s0, 0);
    repeat (2) @(negedge ck);

    // Reset in EXEC cycle 2 of a multiply
    s0 = stb_cnt;
    send(8'hF6);
    @(negedge ck);
    #2 clear = 1'b0;
    #1;
    chk("abort_ready",   instr_ready, 0);
    chk("abort_busy",    busy,        0);
    chk("abort_rd_en",   rd_en,       0);
    chk("abort_res",     res_en,      0);
    chk("abort_stb",     wr_stb,      0);
    chk("abort_retired", retired,     0);
    chk("abort_a",       rd_a_sel,    0);
    chk("abort_imm",     imm,         0);
    repeat (2) @(negedge ck);
    clear = 1'b1;
    @(negedge ck);
    chk("abort_release_ready", instr_ready, 1);
    #1 chk("abort_stb_count", stb_cnt - s0, 0);

    // 256 back-to-back ADDs with valid held high
    s0   = stb_cnt;
    r0   = retired;
    sent = 0;
    rb   = 8'($urandom);
    rb[7:6] = 2'b00;
    instr = rb;
    @(negedge ck);
    instr_valid = 1'b1;
    for (int c = 0; c < 1200 && sent < 256; c++) begin
      took = instr_ready;
      if (took) sent++;
      @(negedge ck);
      if (took) begin
        rb = 8'($urandom);
        rb[7:6] = 2'b00;
        instr = rb;
      end
    end
    instr_valid = 1'b0;
    repeat (4) @(negedge ck);
    #1;
    chk("b2b_sent",      sent,          256);
    chk("b2b_stb_count", stb_cnt - s0,  256);
    chk("b2b_retired",   retired,       r0);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge ck);
      if ($urandom_range(0, 39) == 0) begin
        #2 clear = 1'b0;
        @(negedge ck);
        clear = 1'b1;
      end
      send(8'($urandom));
    end
    repeat (12) @(negedge ck);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller for the four-register, 8-bit add/multiply/load-immediate datapath. It accepts 8-bit instructions over a valid/ready handshake and decodes them. It drives the source-register read decoders, the result tri-state enables and the destination register write strobe, and it holds the operands stable for the full multiplier settle time. It sits between the instruction source (DIP/program feeder) and the register file/ALU.

## Interface
Parameters:
- MUL_CYCLES, 4, number of EXEC cycles for a multiply (values below 1 are treated as 1)

Ports:
- ck  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-low
- instr  in  8  instruction byte; [7:6] opcode, [5:4] dest reg, [3:2] src A, [1:0] src B
- instr_valid  in  1  instr holds a valid byte
- instr_ready  out  1  sequencer accepts a byte on this edge
- rd_en  out  1  enable for both read decoders
- rd_a_sel  out  2  src A register index
- rd_b_sel  out  2  src B register index
- res_en  out  3  one-hot result bus driver: [0] add, [1] immediate, [2] mul
- imm  out  8  immediate value driven onto the result bus
- wr_sel  out  2  destination register index
- wr_stb  out  1  destination register clock pulse (one cycle)
- busy  out  1  instruction in flight
- illegal  out  1  one-cycle pulse on opcode 10
- retired  out  8  count of completed writes, wraps

## Operation
- Opcodes: 00 ADD, 01 LDI, 10 illegal, 11 MUL. LDI is two bytes: the opcode byte carries dest in [5:4], and the next accepted byte is the full 8-bit immediate. Bits [3:0] of the LDI opcode byte are ignored.
- States: FETCH, IMM, EXEC, WRITE.
- FETCH: instr_ready=1. On instr_valid&instr_ready, instr is latched and the next state is chosen:
  - ADD or MUL -> EXEC
  - LDI -> IMM
  - 10 -> FETCH, with illegal=1 for one cycle and no other effect
- IMM: instr_ready=1. The handshake latches imm and moves to EXEC.
- EXEC:
  - rd_en=1; rd_a_sel and rd_b_sel come from the latched instruction.
  - res_en is set per opcode. LDI sets rd_en=0 and drives only res_en[1].
  - A down-counter is loaded with 1 (ADD, LDI) or MUL_CYCLES (MUL). The state stays in EXEC until the counter expires, then moves to WRITE.
- WRITE:
  - rd_en, the selects, res_en and imm all hold their EXEC values.
  - wr_sel = dest and wr_stb=1 for exactly one cycle.
  - retired increments (255 -> 0).
  - Next state is FETCH.
- busy=1 in IMM, EXEC and WRITE; busy=0 in FETCH.
- instr is sampled only at the handshake edge. Changes while instr_ready=0 are ignored.
- All outputs are registered and glitch-free. wr_stb never asserts without a selected res_en.

## Timing
- Reset (clear=0, any time, asynchronous):
  - state=FETCH
  - instr_ready=0, rd_en=0, rd_a_sel=0, rd_b_sel=0, res_en=000, imm=0, wr_sel=0, wr_stb=0, busy=0, illegal=0, retired=0
- First rising ck after clear releases: instr_ready=1.
- Reset during EXEC or WRITE aborts the instruction. No wr_stb is issued, or an already-asserted wr_stb drops immediately. retired is cleared.
- Latency is counted from the handshake edge e0:
  - ADD: EXEC during e0..e1, WRITE (wr_stb=1) during e1..e2, instr_ready=1 from e2. The next handshake is possible at e3, so throughput is one instruction per 3 cycles.
  - MUL: EXEC during e0..e(MUL_CYCLES), WRITE during e(MUL_CYCLES)..e(MUL_CYCLES+1), instr_ready=1 from e(MUL_CYCLES+1).
  - LDI: from the second-byte handshake, the timing is the same as ADD. The bubble between the opcode and immediate bytes is unlimited.
  - Illegal: illegal=1 during e0..e1. instr_ready drops to 0 for that cycle and returns to 1 at e1.
- instr_ready falls on the same edge as the handshake.
- The register file captures on the rising edge of wr_stb. Operands and the result bus are stable from the start of EXEC through the end of WRITE.

## Test plan
- Reset release, then ADD 0x1B (dest 1, A 2, B 3): rd_a_sel=2 and rd_b_sel=3 from e0; res_en=001; wr_stb=1 with wr_sel=1 in cycle e1..e2 only; retired=1; instr_ready=1 at e2.
- MUL 0xF6 with MUL_CYCLES=4: EXEC lasts 4 cycles with res_en=100 and rd_en=1; wr_stb at e4..e5 with wr_sel=3; no earlier strobe.
- LDI 0x50, instr_valid low for 3 cycles, then 0xA5: busy=1 throughout the gap; imm=0xA5; res_en=010; rd_en=0; wr_sel=1; one wr_stb.
- Opcode 0x80, then ADD: illegal pulses 1 cycle; no wr_stb; retired unchanged; ADD accepted at e2.
- Assert clear mid-MUL at EXEC cycle 2: all outputs go to reset values immediately; no wr_stb; after release, instr_ready=1 on the first edge.
- 256 back-to-back ADDs with instr_valid held high: exactly 256 wr_stb pulses, one every 3 cycles; retired wraps 255 -> 0.
